// File: rtl/pc_pkg.sv
// Shared definitions for the program counter with return stack.
// Operation encoding, legal parameter ranges and the priority decode.
package pc_pkg;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 16;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 16;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_JMP  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } op_e;

  // Return beats call beats jump beats count; exactly one op per edge.
  function automatic op_e decode_op(input logic ret_n, input logic call_n,
                                    input logic j_n, input logic ce);
    if (!ret_n)       return OP_RET;
    else if (!call_n) return OP_CALL;
    else if (!j_n)    return OP_JMP;
    else if (ce)      return OP_INC;
    else              return OP_HOLD;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO return-address stack; push/pop take effect on the rising edge.
// Top of stack is read combinationally; push when full and pop when empty are ignored.
module pc_ret_stack #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int SPW  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_dat,
  output logic [WIDTH-1:0] top_dat,
  output logic [SPW-1:0]   sp,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SPW-1:0]   sp_q;
  logic [AW-1:0]    top_idx;
  logic             do_push;
  logic             do_pop;

  assign full    = (sp_q == SPW'(DEPTH));
  assign empty   = (sp_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign top_idx = AW'(sp_q - SPW'(1));
  assign top_dat = mem[top_idx];
  assign sp      = sp_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sp_q <= '0;
    end else if (do_push) begin
      sp_q <= sp_q + SPW'(1);
    end else if (do_pop) begin
      sp_q <= sp_q - SPW'(1);
    end
  end

  // Entries are never read while empty, so they carry no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[sp_q[AW-1:0]] <= push_dat;
    end
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with count/jump/call/return and a tri-state bus output.
// One-cycle latency for every operation; bus is released whenever a load is requested.
module pc_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   ce,
  input  logic                   j_n,
  input  logic                   call_n,
  input  logic                   ret_n,
  input  logic                   co_n,
  inout  wire  [WIDTH-1:0]       bus,
  output logic [$clog2(DEPTH):0] sp,
  output logic                   full,
  output logic                   empty,
  output logic                   err,
  output logic                   wrap
);

  op_e              op;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] top_dat;

  assign op     = decode_op(ret_n, call_n, j_n, ce);
  assign pc_inc = pc + WIDTH'(1);

  pc_ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk      (clk),
    .clr_n    (clr_n),
    .push     (op == OP_CALL),
    .pop      (op == OP_RET),
    .push_dat (pc_inc),
    .top_dat  (top_dat),
    .sp       (sp),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pc   <= '0;
      err  <= 1'b0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (op)
        OP_RET: begin
          if (empty) err <= 1'b1;
          else       pc  <= top_dat;
        end
        OP_CALL: begin
          if (full) err <= 1'b1;
          else      pc  <= bus;
        end
        OP_JMP: pc <= bus;
        OP_INC: begin
          pc   <= pc_inc;
          wrap <= &pc;
        end
        default: ;
      endcase
    end
  end

  // Any load request releases the bus so the source can drive it.
  assign bus = (!co_n && j_n && call_n) ? pc : {WIDTH{1'bz}};

endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack (WIDTH=4, DEPTH=4) with directed vectors.
module tb_pc_stack;

  typedef struct {
    bit         bus_only;
    string      name;
    logic [3:0] pc;
    logic [2:0] sp;
    logic       err;
    logic       wrap;
  } exp_t;

  logic       clk;
  logic       clr_n;
  logic       ce;
  logic       j_n;
  logic       call_n;
  logic       ret_n;
  logic       co_n;
  logic       drv_en;
  logic [3:0] drv_dat;
  wire  [3:0] bus;
  logic [2:0] sp;
  logic       full;
  logic       empty;
  logic       err;
  logic       wrap;

  exp_t sb[$];
  event chk_ev;
  int   errors = 0;
  int   checks = 0;

  assign bus = drv_en ? drv_dat : 4'bzzzz;

  pc_stack #(.WIDTH(4), .DEPTH(4)) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .ce     (ce),
    .j_n    (j_n),
    .call_n (call_n),
    .ret_n  (ret_n),
    .co_n   (co_n),
    .bus    (bus),
    .sp     (sp),
    .full   (full),
    .empty  (empty),
    .err    (err),
    .wrap   (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input bit bo, input string nm, input logic [3:0] epc,
                          input logic [2:0] esp, input logic eerr, input logic ewrap);
    exp_t e;
    e.bus_only = bo;
    e.name     = nm;
    e.pc       = epc;
    e.sp       = esp;
    e.err      = eerr;
    e.wrap     = ewrap;
    sb.push_back(e);
  endtask

  // Inputs change just after a falling edge; the state after the next rising
  // edge is observed on bus (co_n low, bench not driving) at the falling edge.
  task automatic step(input string nm, input logic ce_i, input logic j_i,
                      input logic call_i, input logic ret_i, input logic [3:0] d,
                      input logic [3:0] epc, input logic [2:0] esp,
                      input logic eerr, input logic ewrap);
    @(negedge clk);
    #1;
    ce      = ce_i;
    j_n     = j_i;
    call_n  = call_i;
    ret_n   = ret_i;
    co_n    = 1'b0;
    drv_en  = !j_i || !call_i;
    drv_dat = d;
    if (!j_i || !call_i) begin
      #1;
      push_exp(1'b1, {nm, "_busrel"}, d, 3'd0, 1'b0, 1'b0);
      ->chk_ev;
    end
    @(posedge clk);
    #1;
    ce     = 1'b0;
    j_n    = 1'b1;
    call_n = 1'b1;
    ret_n  = 1'b1;
    drv_en = 1'b0;
    push_exp(1'b0, nm, epc, esp, eerr, ewrap);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (e.bus_only) begin
          if (bus !== e.pc) begin
            errors++;
            $display("FAIL %s: bus=%0h required %0h", e.name, bus, e.pc);
          end
        end else if (bus !== e.pc || sp !== e.sp || full !== (e.sp == 3'd4) ||
                     empty !== (e.sp == 3'd0) || err !== e.err || wrap !== e.wrap) begin
          errors++;
          $display("FAIL %s: pc=%0h sp=%0d full=%b empty=%b err=%b wrap=%b required pc=%0h sp=%0d full=%b empty=%b err=%b wrap=%b",
                   e.name, bus, sp, full, empty, err, wrap,
                   e.pc, e.sp, e.sp == 3'd4, e.sp == 3'd0, e.err, e.wrap);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    clr_n   = 1'b0;
    ce      = 1'b0;
    j_n     = 1'b1;
    call_n  = 1'b1;
    ret_n   = 1'b1;
    co_n    = 1'b0;
    drv_en  = 1'b0;
    drv_dat = 4'h0;
    #2;
    push_exp(1'b0, "reset", 4'h0, 3'd0, 1'b0, 1'b0);
    ->chk_ev;
    @(negedge clk);
    #1;
    clr_n = 1'b1;

    //   name       ce j  cl rt bus   pc    sp   err  wrap
    step("inc1",    1, 1, 1, 1, 4'h0, 4'h1, 3'd0, 0, 0);
    step("inc2",    1, 1, 1, 1, 4'h0, 4'h2, 3'd0, 0, 0);
    step("inc3",    1, 1, 1, 1, 4'h0, 4'h3, 3'd0, 0, 0);
    step("inc4",    1, 1, 1, 1, 4'h0, 4'h4, 3'd0, 0, 0);
    step("inc5",    1, 1, 1, 1, 4'h0, 4'h5, 3'd0, 0, 0);
    step("jmp14",   0, 0, 1, 1, 4'he, 4'he, 3'd0, 0, 0);
    step("inc15",   1, 1, 1, 1, 4'h0, 4'hf, 3'd0, 0, 0);
    step("wrap0",   1, 1, 1, 1, 4'h0, 4'h0, 3'd0, 0, 1);
    step("wrapend", 0, 1, 1, 1, 4'h0, 4'h0, 3'd0, 0, 0);
    step("jmp3",    0, 0, 1, 1, 4'h3, 4'h3, 3'd0, 0, 0);
    step("call9",   0, 1, 0, 1, 4'h9, 4'h9, 3'd1, 0, 0);
    step("ret4",    0, 1, 1, 0, 4'h0, 4'h4, 3'd0, 0, 0);
    step("callA",   0, 1, 0, 1, 4'h5, 4'h5, 3'd1, 0, 0);
    step("callB",   0, 1, 0, 1, 4'h6, 4'h6, 3'd2, 0, 0);
    step("callC",   0, 1, 0, 1, 4'h7, 4'h7, 3'd3, 0, 0);
    step("callD",   0, 1, 0, 1, 4'h8, 4'h8, 3'd4, 0, 0);
    step("callfull",0, 1, 0, 1, 4'h9, 4'h8, 3'd4, 1, 0);
    step("retD",    0, 1, 1, 0, 4'h0, 4'h8, 3'd3, 1, 0);
    step("retC",    0, 1, 1, 0, 4'h0, 4'h7, 3'd2, 1, 0);
    step("retB",    0, 1, 1, 0, 4'h0, 4'h6, 3'd1, 1, 0);
    step("retA",    0, 1, 1, 0, 4'h0, 4'h5, 3'd0, 1, 0);
    step("jmp0",    0, 0, 1, 1, 4'h0, 4'h0, 3'd0, 1, 0);
    step("call10",  0, 1, 0, 1, 4'ha, 4'ha, 3'd1, 1, 0);
    step("call11",  0, 1, 0, 1, 4'hb, 4'hb, 3'd2, 1, 0);

    // Asynchronous clear in the middle of the low clock phase.
    @(negedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    push_exp(1'b0, "async_clr", 4'h0, 3'd0, 1'b0, 1'b0);
    ->chk_ev;
    #1;
    clr_n = 1'b1;

    step("inc_after_clr", 1, 1, 1, 1, 4'h0, 4'h1, 3'd0, 0, 0);
    step("ret_wins",      1, 1, 0, 0, 4'hc, 4'h1, 3'd0, 1, 0);
    step("ret_empty2",    0, 1, 1, 0, 4'h0, 4'h1, 3'd0, 1, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: pending=%0d required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
